// File: rtl/banked_program_rom.sv
// Banked program ROM held in one dual-port RAM, loaded through the download port.
// CPU reads are gated by a load-status FSM and return all ones until a full image is present.
module banked_program_rom #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int NUM_BANKED = 2,
    parameter int NUM_BANKS  = 2,
    parameter int NUM_FIXED  = 1,
    parameter int BANK_W     = 1,
    parameter int LOAD_W     = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [ADDR_W-1:0]                  addr,
    input  logic [NUM_BANKED+NUM_FIXED-1:0]    rom_cs_n,
    input  logic                               rd,
    input  logic                               bank_we,
    input  logic [BANK_W-1:0]                  bank_din,
    output logic [DATA_W-1:0]                  dout,
    output logic                               dout_valid,
    input  logic                               dl_active,
    input  logic                               dl_wr,
    input  logic [LOAD_W-1:0]                  dl_addr,
    input  logic [DATA_W-1:0]                  dl_data,
    output logic                               ready,
    output logic                               load_error
);
    localparam int NREG   = NUM_BANKED + NUM_FIXED;
    localparam int NCHIP  = NUM_BANKED * NUM_BANKS + NUM_FIXED;
    localparam int TOTAL  = NCHIP * (2 ** ADDR_W);
    localparam int CHIP_W = (NCHIP > 1) ? $clog2(NCHIP) : 1;
    localparam int RAM_AW = CHIP_W + ADDR_W;
    localparam int CNT_W  = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {S_EMPTY, S_LOADING, S_READY, S_ERROR} state_t;

    state_t              r_state, w_next;
    logic [BANK_W-1:0]   r_bank;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_mem [TOTAL];
    logic [RAM_AW-1:0]   r_rd_addr;
    logic                r_ok_s1;
    logic                r_rd_ok;
    logic [DATA_W-1:0]   r_ram_q;
    logic [1:0]          r_vld_pipe;
    logic [CHIP_W-1:0]   w_chip;
    logic [RAM_AW-1:0]   w_rd_addr;
    logic                w_wr_en;

    // Lowest asserted select wins; nothing asserted falls back to the last region.
    always_comb begin
        int reg_i;
        int chip_i;
        reg_i = NREG - 1;
        for (int r = NREG - 1; r >= 0; r--)
            if (!rom_cs_n[r]) reg_i = r;
        if (reg_i < NUM_BANKED) chip_i = reg_i * NUM_BANKS + int'(r_bank);
        else                    chip_i = NUM_BANKED * NUM_BANKS + reg_i - NUM_BANKED;
        w_chip = CHIP_W'(chip_i);
    end

    assign w_rd_addr = {w_chip, addr};
    assign w_wr_en   = (r_state == S_LOADING) && dl_wr && (32'(dl_addr) < TOTAL);

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[dl_addr[RAM_AW-1:0]] <= dl_data;
    end

    always_ff @(posedge clk) begin
        if (r_vld_pipe[0]) r_ram_q <= r_mem[r_rd_addr];
    end

    // Stage 0 captures the request at the rd edge, stage 1 presents data one edge later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_pipe <= '0;
            r_rd_addr  <= '0;
            r_ok_s1    <= 1'b0;
            r_rd_ok    <= 1'b0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], rd};
            if (rd) begin
                r_rd_addr <= w_rd_addr;
                r_ok_s1   <= (r_state == S_READY);
            end
            if (r_vld_pipe[0]) r_rd_ok <= r_ok_s1;
        end
    end

    assign dout       = r_rd_ok ? r_ram_q : '1;
    assign dout_valid = r_vld_pipe[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                        r_bank <= '0;
        else if (bank_we && (32'(bank_din) < NUM_BANKS)) r_bank <= bank_din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_EMPTY;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_EMPTY:   if (dl_active) w_next = S_LOADING;
            S_LOADING: if (!dl_active) w_next = (32'(r_cnt) == TOTAL) ? S_READY : S_ERROR;
            S_READY,
            S_ERROR:   if (dl_active) w_next = S_LOADING;
            default:   w_next = S_EMPTY;
        endcase
    end

    // Counts accepted writes, not distinct addresses; saturates at the image size.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (r_state != S_LOADING && w_next == S_LOADING)
            r_cnt <= '0;
        else if (w_wr_en && 32'(r_cnt) != TOTAL)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign ready      = (r_state == S_READY);
    assign load_error = (r_state == S_ERROR);
endmodule

// File: tb/tb_banked_program_rom.sv
// Self-checking bench for banked_program_rom, run with a 1 KB chip size so full
// image downloads stay short; expectations come from a byte-array image model.
module tb_banked_program_rom;
    localparam int ADDR_W     = 10;
    localparam int NUM_BANKED = 2;
    localparam int NUM_BANKS  = 2;
    localparam int NUM_FIXED  = 1;
    localparam int NREG       = NUM_BANKED + NUM_FIXED;
    localparam int CHIP_SZ    = 2 ** ADDR_W;
    localparam int TOTAL      = (NUM_BANKED * NUM_BANKS + NUM_FIXED) * CHIP_SZ;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] addr = '0;
    logic [NREG-1:0]   rom_cs_n = '1;
    logic              rd = 1'b0;
    logic              bank_we = 1'b0;
    logic [0:0]        bank_din = '0;
    logic [7:0]        dout;
    logic              dout_valid;
    logic              dl_active = 1'b0;
    logic              dl_wr = 1'b0;
    logic [15:0]       dl_addr = '0;
    logic [7:0]        dl_data = '0;
    logic              ready;
    logic              load_error;

    int errs = 0;
    int checks = 0;

    logic [7:0] mdl_mem [TOTAL];
    int         mdl_bank = 0;
    bit         mdl_ready = 0;

    banked_program_rom #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .addr(addr), .rom_cs_n(rom_cs_n), .rd(rd),
        .bank_we(bank_we), .bank_din(bank_din), .dout(dout), .dout_valid(dout_valid),
        .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .ready(ready), .load_error(load_error)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pattern(input int i);
        return 8'(i) ^ 8'(i >> ADDR_W);
    endfunction

    function automatic int chip_of(input logic [NREG-1:0] cs, input int bank);
        int r;
        r = NREG - 1;
        for (int k = 0; k < NREG; k++)
            if (!cs[k]) begin r = k; break; end
        if (r < NUM_BANKED) return r * NUM_BANKS + bank;
        return NUM_BANKED * NUM_BANKS + r - NUM_BANKED;
    endfunction

    function automatic logic [7:0] exp_read(input logic [NREG-1:0] cs, input logic [ADDR_W-1:0] a);
        if (!mdl_ready) return 8'hFF;
        return mdl_mem[chip_of(cs, mdl_bank) * CHIP_SZ + int'(a)];
    endfunction

    // Issues one read and advances to the edge where its data appears.
    task automatic do_rd(input logic [NREG-1:0] cs, input logic [ADDR_W-1:0] a);
        rom_cs_n = cs; addr = a; rd = 1'b1;
        tick();
        rd = 1'b0;
        tick();
    endtask

    // Download body: n writes at 0..n-1, optionally random data with idle and out-of-range writes.
    task automatic load_body(input int n, input bit rnd);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            if (rnd && $urandom_range(0, 7) == 0) begin
                dl_wr = 1'b1; dl_addr = 16'(TOTAL + int'($urandom_range(0, 65535 - TOTAL)));
                dl_data = 8'($urandom); tick();
            end
            if (rnd && $urandom_range(0, 7) == 0) begin
                dl_wr = 1'b0; tick();
            end
            d = rnd ? 8'($urandom) : pattern(i);
            dl_wr = 1'b1; dl_addr = 16'(i); dl_data = d; mdl_mem[i] = d;
            tick();
        end
        dl_wr = 1'b0; dl_active = 1'b0;
        tick();
        mdl_ready = (n >= TOTAL);
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (dout !== 8'hFF || dout_valid !== 1'b0 || ready !== 1'b0 || load_error !== 1'b0) begin
            errs++;
            $display("FAIL reset_state: dout=%h vld=%b rdy=%b err=%b, want ff 0 0 0", dout, dout_valid, ready, load_error);
        end
        #4 reset = 1'b0;
        tick();
        do_rd(3'b111, '0);
        checks++;
        if (dout !== 8'hFF || dout_valid !== 1'b1 || ready !== 1'b0) begin
            errs++;
            $display("FAIL empty_read: dout=%h vld=%b rdy=%b, want ff 1 0", dout, dout_valid, ready);
        end
        tick();
        checks++;
        if (dout_valid !== 1'b0 || dout !== 8'hFF) begin
            errs++;
            $display("FAIL empty_read_pulse: dout=%h vld=%b, want ff 0", dout, dout_valid);
        end
    endtask

    task automatic test_full_load();
        dl_active = 1'b1;
        tick();
        load_body(TOTAL, 1'b0);
        checks++;
        if (ready !== 1'b1 || load_error !== 1'b0) begin
            errs++;
            $display("FAIL full_load_status: rdy=%b err=%b, want 1 0", ready, load_error);
        end
        do_rd(3'b011, 10'h005);
        checks++;
        if (dout !== 8'h01 || dout !== exp_read(3'b011, 10'h005) || dout_valid !== 1'b1) begin
            errs++;
            $display("FAIL fixed_read: dout=%h vld=%b, want 01 1", dout, dout_valid);
        end
        tick();
        checks++;
        if (dout !== 8'h01 || dout_valid !== 1'b0) begin
            errs++;
            $display("FAIL dout_hold: dout=%h vld=%b, want 01 0", dout, dout_valid);
        end
    endtask

    task automatic test_bank_switch();
        logic [7:0] e_old;
        logic [7:0] e_new;
        e_old = exp_read(3'b110, 10'h010);
        rom_cs_n = 3'b110; addr = 10'h010; rd = 1'b1; bank_we = 1'b1; bank_din = 1'b1;
        tick();
        mdl_bank = 1;
        e_new = exp_read(3'b110, 10'h010);
        bank_we = 1'b0;
        tick();
        checks++;
        if (dout !== e_old || dout !== 8'h10 || dout_valid !== 1'b1) begin
            errs++;
            $display("FAIL bank_old: dout=%h vld=%b, want %h 1", dout, dout_valid, e_old);
        end
        rd = 1'b0;
        tick();
        checks++;
        if (dout !== e_new || dout !== 8'h11 || dout_valid !== 1'b1) begin
            errs++;
            $display("FAIL bank_new: dout=%h vld=%b, want %h 1", dout, dout_valid, e_new);
        end
    endtask

    task automatic test_priority();
        bank_we = 1'b1; bank_din = 1'b0;
        tick();
        bank_we = 1'b0; mdl_bank = 0;
        do_rd(3'b100, '0);
        checks++;
        if (dout !== 8'h00 || dout !== exp_read(3'b100, '0)) begin
            errs++;
            $display("FAIL prio_r0: dout=%h, want 00", dout);
        end
        do_rd(3'b101, 10'h3);
        checks++;
        if (dout !== exp_read(3'b101, 10'h3)) begin
            errs++;
            $display("FAIL prio_r1: dout=%h, want %h", dout, exp_read(3'b101, 10'h3));
        end
        do_rd(3'b000, 10'h7);
        checks++;
        if (dout !== exp_read(3'b000, 10'h7)) begin
            errs++;
            $display("FAIL prio_all: dout=%h, want %h", dout, exp_read(3'b000, 10'h7));
        end
    endtask

    // Random reads, selects and bank writes on every cycle, checked one edge behind.
    task automatic run_stream(input int n, input bit rnd, input string tag);
        bit         p_rd;
        logic [7:0] p_exp;
        logic [7:0] held;
        bit         c_rd;
        logic [7:0] c_exp;
        p_rd = 0; p_exp = 8'hFF; held = dout;
        for (int i = 0; i <= n; i++) begin
            c_rd = (i < n) && (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
            rd = c_rd;
            rom_cs_n = rnd ? NREG'($urandom) : 3'b011;
            addr = rnd ? ADDR_W'($urandom) : ADDR_W'(i);
            bank_we = rnd && (i < n) && ($urandom_range(0, 3) == 0);
            bank_din = 1'($urandom);
            c_exp = exp_read(rom_cs_n, addr);
            tick();
            if (bank_we) mdl_bank = int'(bank_din);
            if (p_rd) held = p_exp;
            checks++;
            if (dout_valid !== p_rd || dout !== held) begin
                errs++;
                $display("FAIL %s[%0d]: dout=%h vld=%b, want %h %b", tag, i, dout, dout_valid, held, p_rd);
            end
            p_rd = c_rd; p_exp = c_exp;
        end
        rd = 1'b0; bank_we = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_stream(24, 1'b0, "b2b");
    endtask

    task automatic test_random_reads();
        run_stream(300, 1'b1, "rand");
    endtask

    task automatic test_short_load();
        logic [7:0] e;
        dl_active = 1'b1;
        tick();
        checks++;
        if (ready !== 1'b0 || load_error !== 1'b0) begin
            errs++;
            $display("FAIL reload_drop: rdy=%b err=%b, want 0 0", ready, load_error);
        end
        mdl_ready = 0;
        load_body(TOTAL - 1, 1'b1);
        checks++;
        if (ready !== 1'b0 || load_error !== 1'b1) begin
            errs++;
            $display("FAIL short_status: rdy=%b err=%b, want 0 1", ready, load_error);
        end
        do_rd(3'b011, 10'h005);
        checks++;
        if (dout !== 8'hFF || dout_valid !== 1'b1) begin
            errs++;
            $display("FAIL short_read: dout=%h vld=%b, want ff 1", dout, dout_valid);
        end
        dl_active = 1'b1;
        tick();
        checks++;
        if (load_error !== 1'b0 || ready !== 1'b0) begin
            errs++;
            $display("FAIL err_drop: rdy=%b err=%b, want 0 0", ready, load_error);
        end
        dl_wr = 1'b1; dl_addr = 16'hA000; dl_data = 8'h5A;
        tick();
        load_body(TOTAL, 1'b1);
        checks++;
        if (ready !== 1'b1 || load_error !== 1'b0) begin
            errs++;
            $display("FAIL redl_status: rdy=%b err=%b, want 1 0", ready, load_error);
        end
        e = exp_read(3'b110, '0);
        do_rd(3'b110, '0);
        checks++;
        if (dout !== e) begin
            errs++;
            $display("FAIL oor_ignored: dout=%h, want %h", dout, e);
        end
        run_stream(60, 1'b1, "redl_rand");
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] d;
        bank_we = 1'b1; bank_din = 1'b1;
        tick();
        bank_we = 1'b0; mdl_bank = 1;
        dl_active = 1'b1;
        tick();
        for (int i = 0; i < 100; i++) begin
            d = 8'($urandom);
            dl_wr = 1'b1; dl_addr = 16'(i); dl_data = d; mdl_mem[i] = d;
            tick();
        end
        reset = 1'b1;
        #2;
        mdl_ready = 0; mdl_bank = 0;
        checks++;
        if (ready !== 1'b0 || load_error !== 1'b0 || dout !== 8'hFF || dout_valid !== 1'b0) begin
            errs++;
            $display("FAIL midload_reset: rdy=%b err=%b dout=%h vld=%b, want 0 0 ff 0", ready, load_error, dout, dout_valid);
        end
        dl_wr = 1'b0; dl_active = 1'b0;
        reset = 1'b0;
        tick();
        do_rd(3'b110, 10'h003);
        checks++;
        if (dout !== 8'hFF || dout_valid !== 1'b1) begin
            errs++;
            $display("FAIL midload_read: dout=%h vld=%b, want ff 1", dout, dout_valid);
        end
        dl_active = 1'b1;
        tick();
        load_body(TOTAL, 1'b0);
        do_rd(3'b110, 10'h010);
        checks++;
        if (dout !== 8'h10 || dout !== exp_read(3'b110, 10'h010)) begin
            errs++;
            $display("FAIL bank_after_reset: dout=%h, want 10", dout);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_bank_switch();
        test_priority();
        test_back_to_back();
        test_random_reads();
        test_short_load();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/banked_program_rom.md
Name: banked_program_rom

Overview:
- Parametrised successor to the fixed five-chip program ROM decode.
- Holds N chip-select regions of 2^ADDR_W bytes each in one block RAM. The first NUM_BANKED regions are bank-switched through an internal bank register; the remaining NUM_FIXED regions are unbanked.
- Contents are loaded at runtime from the MiSTer download port. A load-status state machine gates CPU reads.
- Sits between the CPU address decode and the data-bus mux. Replaces INIT_FILE-based ROM instances.

Parameters:
- ADDR_W, 13: address bits per chip (8 KB at default).
- DATA_W, 8: data width.
- NUM_BANKED, 2: banked chip-select regions.
- NUM_BANKS, 2: banks per banked region.
- NUM_FIXED, 1: unbanked regions.
- BANK_W, 1: bank register width. Must satisfy 2^BANK_W >= NUM_BANKS.
- LOAD_W, 16: download address width. Must satisfy 2^LOAD_W >= TOTAL.
- Derived: NREG = NUM_BANKED+NUM_FIXED; NCHIP = NUM_BANKED*NUM_BANKS+NUM_FIXED; TOTAL = NCHIP*2^ADDR_W. Defaults give NREG=3, NCHIP=5, TOTAL=40960.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- addr  in  ADDR_W  CPU address within chip
- rom_cs_n  in  NREG  active-low region selects; bit r = region r
- rd  in  1  read request strobe, one cycle
- bank_we  in  1  bank register write strobe
- bank_din  in  BANK_W  new bank value
- dout  out  DATA_W  read data
- dout_valid  out  1  one-cycle pulse when dout is updated
- dl_active  in  1  download in progress
- dl_wr  in  1  download byte write strobe
- dl_addr  in  LOAD_W  linear download byte address
- dl_data  in  DATA_W  download byte
- ready  out  1  image loaded and complete
- load_error  out  1  last download was short

Behaviour:
- Reset (asynchronous, immediate):
  - dout = all ones, dout_valid = 0.
  - bank = 0, state = EMPTY, ready = 0, load_error = 0, byte counter = 0.
  - RAM contents are not cleared.
- Chip index mapping:
  - Banked region r (r < NUM_BANKED) with bank b maps to chip r*NUM_BANKS+b.
  - Fixed region r maps to chip NUM_BANKED*NUM_BANKS + (r-NUM_BANKED).
  - RAM byte address = chip*2^ADDR_W + addr. The download image uses the same layout.
- Region resolve:
  - The lowest-index asserted rom_cs_n bit wins.
  - If no bit is asserted, the last region (NREG-1) is selected, matching the legacy default decode.
- Bank register:
  - Written on a clk edge when bank_we=1.
  - If bank_din >= NUM_BANKS, the write is ignored and the bank is unchanged.
  - A read in the same cycle as bank_we uses the old bank; the new value applies from the next cycle.
- Read, latency 1:
  - A read is sampled when rd=1 at edge N.
  - At edge N+1, dout is the RAM byte and dout_valid=1 for exactly one cycle.
  - dout holds its value until the next read.
  - Back-to-back rd every cycle is supported at full throughput.
  - If state != READY, a read returns all ones with dout_valid still pulsed, so the CPU never stalls.
- Load state machine:
  - EMPTY: dl_active=1 -> LOADING; clear counter.
  - LOADING:
    - dl_wr=1 with dl_addr < TOTAL writes the RAM and increments the counter (saturating at TOTAL).
    - dl_addr >= TOTAL is ignored and not counted.
    - When dl_active falls: counter == TOTAL -> READY (ready=1, load_error=0); otherwise -> ERROR (load_error=1, ready=0).
  - READY / ERROR: dl_active rise -> LOADING. ready and load_error drop in the same cycle; counter clears.
  - dl_wr outside LOADING is ignored.
  - The counter counts writes, not distinct addresses.
- A download write and a CPU read in the same cycle are independent (true dual-port RAM).
- Reset mid-load returns to EMPTY; the partial image remains in RAM but is not readable (reads return all ones).

Test Plan:
- Reset, then rd with rom_cs_n=3'b111 -> dout=8'hFF, dout_valid=1 one cycle later, ready=0.
- Download 40960 bytes with byte[i] = i[7:0] ^ (i>>13), then drop dl_active -> ready=1, load_error=0. Read addr=13'h0005 with rom_cs_n=3'b011 (region 2, chip 4) -> dout=8'h01 at N+1.
- Bank switching: bank_we=1, bank_din=1 with rd on region 0, addr=13'h0010 in the same cycle -> dout=8'h10 (old bank). Repeat the read next cycle -> dout=8'h11 (chip 1).
- Short download of 40959 bytes -> load_error=1, ready=0, reads return 8'hFF. Redownloading the full image -> ready=1, load_error=0.
- rom_cs_n=3'b100 (regions 0 and 1 both asserted), bank=0, addr=0 -> region 0 wins, dout=8'h00. Write to dl_addr=16'hA000 during load is ignored and the count still completes at 40960.
- Assert reset during LOADING after 100 writes -> state EMPTY, ready=0, bank=0. A subsequent read returns 8'hFF.
